// File: rtl/ysyx_2022040010_booth_mul.sv
// Multi-cycle radix-4 Booth multiplier for the EXU (RV64M MUL/MULH/MULHSU/MULHU/MULW).
// One Booth digit is retired per BUSY cycle. The multiplicand is shifted left by two
// places each step, so every partial product lands directly at weight 4^i in a
// 2*XLEN+2 bit accumulator. Handshake outputs depend only on the FSM state.
`timescale 1ns/1ps
module ysyx_2022040010_booth_mul #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            ret,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mul_ina_s,
    input  logic [XLEN-1:0] ina,
    input  logic            mul_inb_s,
    input  logic [XLEN-1:0] inb,
    input  logic [2:0]      sel_mul_hilo,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mul_result,
    output logic            busy
);

    localparam int AW = 2*XLEN + 2;               // accumulator width
    localparam int EW = XLEN + 2;                 // extended operand width
    localparam int CW = $clog2(XLEN/2 + 1) + 1;   // step counter width
    localparam logic [CW-1:0] LAST_FULL = CW'(XLEN/2);
    localparam logic [CW-1:0] LAST_W    = CW'(WLEN/2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   pop;
    logic                   last_step;
    logic                   sel_w;
    logic                   sel_hi;
    logic                   null_op;
    logic                   w_q;
    logic                   hi_q;
    logic [CW-1:0]          cnt;
    logic signed [EW-1:0]   a_ext;
    logic signed [EW-1:0]   b_ext;
    logic signed [AW-1:0]   mcand;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_nxt;
    logic [EW:0]            mplier;

    // Booth digit select: the triplet picks 0, +-A or +-2A of the aligned multiplicand.
    function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                      input logic signed [AW-1:0] m);
        case (trip)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m <<< 1;
            3'b100:         booth_pp = -(m <<< 1);
            3'b101, 3'b110: booth_pp = -m;
            default:        booth_pp = '0;
        endcase
    endfunction

    // Final result slice: W mode sign-extends the low word, otherwise high or low half.
    function automatic logic [XLEN-1:0] pick_result(input logic signed [AW-1:0] p,
                                                    input logic w,
                                                    input logic hi);
        if (w)
            pick_result = {{(XLEN-WLEN){p[WLEN-1]}}, p[WLEN-1:0]};
        else if (hi)
            pick_result = p[2*XLEN-1:XLEN];
        else
            pick_result = p[XLEN-1:0];
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & (state == IDLE) & ~flush;
    assign pop       = (state == DONE) & out_ready;

    // Mode decode (W beats hi beats lo) and operand widening for the accept edge.
    always_comb begin
        sel_w   = sel_mul_hilo[0];
        sel_hi  = ~sel_mul_hilo[0] & sel_mul_hilo[1];
        null_op = (sel_mul_hilo == 3'b000);
        a_ext   = '0;
        b_ext   = '0;
        if (sel_w) begin
            a_ext = {{(EW-WLEN){ina[WLEN-1]}}, ina[WLEN-1:0]};
            b_ext = {{(EW-WLEN){inb[WLEN-1]}}, inb[WLEN-1:0]};
        end else begin
            a_ext = {{2{mul_ina_s & ina[XLEN-1]}}, ina};
            b_ext = {{2{mul_inb_s & inb[XLEN-1]}}, inb};
        end
    end

    // One Booth step: accumulate the current digit's partial product.
    always_comb begin
        acc_nxt   = acc + booth_pp(mplier[2:0], mcand);
        last_step = (cnt == (w_q ? LAST_W : LAST_FULL));
    end

    // State register.
    always_ff @(posedge clk or negedge ret) begin
        if (!ret)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; flush wins over pop and over completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = null_op ? DONE : BUSY;
            BUSY: begin
                if (flush)          state_nxt = IDLE;
                else if (last_step) state_nxt = DONE;
            end
            DONE: if (flush || pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then shift/accumulate one digit per BUSY cycle.
    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            cnt        <= '0;
            w_q        <= 1'b0;
            hi_q       <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            mul_result <= '0;
        end else if (accept) begin
            cnt    <= '0;
            w_q    <= sel_w;
            hi_q   <= sel_hi;
            acc    <= '0;
            mcand  <= {{XLEN{a_ext[EW-1]}}, a_ext};
            mplier <= {b_ext, 1'b0};
            if (null_op)
                mul_result <= '0;
        end else if ((state == BUSY) && !flush) begin
            acc    <= acc_nxt;
            mcand  <= mcand <<< 2;
            mplier <= mplier >> 2;
            cnt    <= cnt + 1'b1;
            if (last_step)
                mul_result <= pick_result(acc_nxt, w_q, hi_q);
        end
    end

endmodule
